// File: rtl/lc3_writeback_stage.sv
// lc3_writeback_stage: LC-3 writeback (mux, regfile, psr, d1/d2 reads, wb_valid/wb_count); clock, reset, enable_writeback, W_control_in, npc/aluout/pcout/memout, sr1/sr2/dr in; d1/d2/psr/wb_valid/wb_count out; `define LC3_WB_BYPASS_EN for write-through forwarding
module lc3_writeback_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [1:0]        W_control_in,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] memout,
  input  logic [REG_AW-1:0] sr1,
  input  logic [REG_AW-1:0] sr2,
  input  logic [REG_AW-1:0] dr,
  output logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] d2,
  output logic [2:0]        psr,
  output logic              wb_valid,
  output logic [15:0]       wb_count
);
  localparam int NUM_REGS = 2**REG_AW;
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d, dr_in, rd1, rd2;
  logic [2:0]        psr_q, psr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [15:0]       wb_count_q, wb_count_d;
  always_comb begin
    dr_in = W_control_in == 2'b00 ? aluout :
            W_control_in == 2'b01 ? memout :
            W_control_in == 2'b10 ? pcout : npc;
`ifdef LC3_WB_BYPASS_EN
    rd1 = sr1 == dr ? dr_in : rf_q[sr1];
    rd2 = sr2 == dr ? dr_in : rf_q[sr2];
`else
    rd1 = rf_q[sr1];
    rd2 = rf_q[sr2];
`endif
    rf_d = rf_q;
    rf_d[dr] = enable_writeback ? dr_in : rf_q[dr];
    psr_d = !enable_writeback ? psr_q :
            dr_in[DATA_W-1]   ? 3'b100 :
            dr_in == '0       ? 3'b010 : 3'b001;
    d1_d = enable_writeback ? rd1 : d1_q;
    d2_d = enable_writeback ? rd2 : d2_q;
    wb_valid_d = enable_writeback;
    wb_count_d = wb_count_q + 16'(enable_writeback);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_q <= '{default: '0};
      d1_q <= '0;
      d2_q <= '0;
      psr_q <= '0;
      wb_valid_q <= 1'b0;
      wb_count_q <= '0;
    end else begin
      rf_q <= rf_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      psr_q <= psr_d;
      wb_valid_q <= wb_valid_d;
      wb_count_q <= wb_count_d;
    end
  end
  assign d1 = d1_q;
  assign d2 = d2_q;
  assign psr = psr_q;
  assign wb_valid = wb_valid_q;
  assign wb_count = wb_count_q;
endmodule
